// File: rtl/booth_iter_mant_mult.sv
// booth_iter_mant_mult: iterative radix-4 Booth mantissa multiplier.
// One Booth digit per enabled cycle; exponent/special-case sideband rides along.
module booth_iter_mant_mult #(
    parameter int EXP       = 5,
    parameter int MANT      = 10,
    parameter int ZERO_SKIP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MANT:0]           mant_a_in,
    input  logic [MANT:0]           mant_b_in,
    input  logic                    sign_in,
    input  logic [EXP-1:0]          exp_a_in,
    input  logic [EXP-1:0]          exp_b_in,
    input  logic [2:0]              spe_case_a_in,
    input  logic [2:0]              spe_case_b_in,
    input  logic                    exp_eq_inf_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*(MANT+1)-1:0]   mant_out,
    output logic                    sign_out,
    output logic [EXP-1:0]          exp_a_out,
    output logic [EXP-1:0]          exp_b_out,
    output logic [2:0]              spe_case_a_out,
    output logic [2:0]              spe_case_b_out,
    output logic                    exp_eq_inf_out
);

    localparam int MANT_IMP = MANT + 1;
    localparam int PW       = 2 * MANT_IMP;
    // multiplier width: even and at least one zero bit above the hidden bit
    localparam int MW       = ((MANT_IMP + 1) % 2 == 0) ? MANT_IMP + 1 : MANT_IMP + 2;
    localparam int N        = MW / 2;
    localparam int SW       = PW + 2;
    localparam int CW       = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] a_sh;
    logic [SW-1:0] acc;
    logic [SW-1:0] pp;
    logic [MW-1:0] b_sh;
    logic          b_prev;
    logic          accept;
    logic          step;
    logic          zero_op;
    logic          last_digit;
    logic          acc_unused;

    assign in_ready   = en & ((state == IDLE) | ((state == DONE) & out_ready));
    assign accept     = in_ready & in_valid;
    assign out_valid  = (state == DONE);
    assign zero_op    = (ZERO_SKIP != 0) &&
                        ((mant_a_in == '0) || (mant_b_in == '0));
    assign last_digit = (cnt == CW'(N - 1));
    assign mant_out   = acc[PW-1:0];
    assign acc_unused = ^acc[SW-1:PW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = zero_op ? DONE : BUSY;
            end
            BUSY: begin
                step = en;
                if (last_digit) state_nxt = DONE;
            end
            DONE: begin
                if (accept) state_nxt = zero_op ? DONE : BUSY;
                else if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Booth digit {b[2i+1], b[2i], b[2i-1]} selects 0, +-A or +-2A
    always_comb begin
        pp = '0;
        unique case ({b_sh[1:0], b_prev})
            3'b001, 3'b010: pp = a_sh;
            3'b011:         pp = a_sh << 1;
            3'b100:         pp = ~(a_sh << 1) + SW'(1);
            3'b101, 3'b110: pp = ~a_sh + SW'(1);
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            a_sh           <= '0;
            b_sh           <= '0;
            b_prev         <= 1'b0;
            acc            <= '0;
            sign_out       <= 1'b0;
            exp_a_out      <= '0;
            exp_b_out      <= '0;
            spe_case_a_out <= '0;
            spe_case_b_out <= '0;
            exp_eq_inf_out <= 1'b0;
        end else if (accept) begin
            cnt            <= '0;
            a_sh           <= {{(SW-MANT_IMP){1'b0}}, mant_a_in};
            b_sh           <= {{(MW-MANT_IMP){1'b0}}, mant_b_in};
            b_prev         <= 1'b0;
            acc            <= '0;
            sign_out       <= sign_in;
            exp_a_out      <= exp_a_in;
            exp_b_out      <= exp_b_in;
            spe_case_a_out <= spe_case_a_in;
            spe_case_b_out <= spe_case_b_in;
            exp_eq_inf_out <= exp_eq_inf_in;
        end else if (step) begin
            cnt    <= cnt + CW'(1);
            acc    <= acc + pp;
            a_sh   <= a_sh << 2;
            b_sh   <= b_sh >> 2;
            b_prev <= b_sh[1];
        end
    end

endmodule

// File: tb/tb_booth_iter_mant_mult.sv
// Self-checking bench for booth_iter_mant_mult: directed corner cases plus
// randomized handshake regression against a plain-multiply scoreboard.
module tb_booth_iter_mant_mult;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // default instance: MANT=10, EXP=5, ZERO_SKIP=1
    logic        en, in_valid, in_ready, out_valid, out_ready;
    logic [10:0] mant_a_in, mant_b_in;
    logic        sign_in, exp_eq_inf_in, sign_out, exp_eq_inf_out;
    logic [4:0]  exp_a_in, exp_b_in, exp_a_out, exp_b_out;
    logic [2:0]  spe_case_a_in, spe_case_b_in, spe_case_a_out, spe_case_b_out;
    logic [21:0] mant_out;

    booth_iter_mant_mult dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .mant_a_in(mant_a_in), .mant_b_in(mant_b_in),
        .sign_in(sign_in), .exp_a_in(exp_a_in), .exp_b_in(exp_b_in),
        .spe_case_a_in(spe_case_a_in), .spe_case_b_in(spe_case_b_in),
        .exp_eq_inf_in(exp_eq_inf_in),
        .out_valid(out_valid), .out_ready(out_ready), .mant_out(mant_out),
        .sign_out(sign_out), .exp_a_out(exp_a_out), .exp_b_out(exp_b_out),
        .spe_case_a_out(spe_case_a_out), .spe_case_b_out(spe_case_b_out),
        .exp_eq_inf_out(exp_eq_inf_out)
    );

    // wide instance: MANT=23, EXP=8, ZERO_SKIP=0 (13 digits)
    logic        w_en, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [23:0] w_mant_a_in, w_mant_b_in;
    logic        w_sign_in, w_exp_eq_inf_in, w_sign_out, w_exp_eq_inf_out;
    logic [7:0]  w_exp_a_in, w_exp_b_in, w_exp_a_out, w_exp_b_out;
    logic [2:0]  w_spa_in, w_spb_in, w_spa_out, w_spb_out;
    logic [47:0] w_mant_out;

    booth_iter_mant_mult #(.EXP(8), .MANT(23), .ZERO_SKIP(0)) dut_w (
        .clk(clk), .rst(rst), .en(w_en),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .mant_a_in(w_mant_a_in), .mant_b_in(w_mant_b_in),
        .sign_in(w_sign_in), .exp_a_in(w_exp_a_in), .exp_b_in(w_exp_b_in),
        .spe_case_a_in(w_spa_in), .spe_case_b_in(w_spb_in),
        .exp_eq_inf_in(w_exp_eq_inf_in),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .mant_out(w_mant_out),
        .sign_out(w_sign_out), .exp_a_out(w_exp_a_out), .exp_b_out(w_exp_b_out),
        .spe_case_a_out(w_spa_out), .spe_case_b_out(w_spb_out),
        .exp_eq_inf_out(w_exp_eq_inf_out)
    );

    function automatic logic [17:0] sb_in();
        return {sign_in, exp_a_in, exp_b_in, spe_case_a_in, spe_case_b_in, exp_eq_inf_in};
    endfunction

    function automatic logic [17:0] sb_out();
        return {sign_out, exp_a_out, exp_b_out, spe_case_a_out, spe_case_b_out, exp_eq_inf_out};
    endfunction

    function automatic logic [23:0] w_sb_in();
        return {w_sign_in, w_exp_a_in, w_exp_b_in, w_spa_in, w_spb_in, w_exp_eq_inf_in};
    endfunction

    function automatic logic [23:0] w_sb_out();
        return {w_sign_out, w_exp_a_out, w_exp_b_out, w_spa_out, w_spb_out, w_exp_eq_inf_out};
    endfunction

    task automatic rand_side();
        sign_in       = 1'($urandom);
        exp_a_in      = 5'($urandom);
        exp_b_in      = 5'($urandom);
        spe_case_a_in = 3'($urandom);
        spe_case_b_in = 3'($urandom);
        exp_eq_inf_in = 1'($urandom);
    endtask

    task automatic w_rand_side();
        w_sign_in       = 1'($urandom);
        w_exp_a_in      = 8'($urandom);
        w_exp_b_in      = 8'($urandom);
        w_spa_in        = 3'($urandom);
        w_spb_in        = 3'($urandom);
        w_exp_eq_inf_in = 1'($urandom);
    endtask

    task automatic offer(input logic [10:0] a, input logic [10:0] b,
                         output logic [21:0] p, output logic [17:0] sb);
        mant_a_in = a;
        mant_b_in = b;
        in_valid  = 1'b1;
        rand_side();
        p  = {11'd0, a} * {11'd0, b};
        sb = sb_in();
    endtask

    // called right after the accepting edge; returns at a negedge with
    // lat = enabled-or-not edges seen after the accepting one
    task automatic wait_done(input int stall_at, output int lat);
        lat = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && lat < 40) begin
            en = !(lat >= stall_at && lat < stall_at + 2);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        mant_a_in = '0; mant_b_in = '0; rand_side();
        w_en = 1'b1; w_in_valid = 1'b0; w_out_ready = 1'b1;
        w_mant_a_in = '0; w_mant_b_in = '0; w_rand_side();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mant_out !== '0 || sb_out() !== '0)
            $display("FAIL reset_state valid=%b mant=%h sb=%h want 0/0/0",
                     out_valid, mant_out, sb_out());
        checks++;
        if (w_out_valid !== 1'b0 || w_mant_out !== '0 || w_sb_out() !== '0)
            $display("FAIL reset_state_w valid=%b mant=%h sb=%h want 0/0/0",
                     w_out_valid, w_mant_out, w_sb_out());
        rst = 1'b0; en = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        if (out_valid !== 1'b0 || mant_out !== '0 || sb_out() !== '0) errors++;
        if (w_out_valid !== 1'b0 || w_mant_out !== '0 || w_sb_out() !== '0) errors++;
    endtask

    task automatic run_op(input string name, input logic [10:0] a,
                          input logic [10:0] b, input int exp_lat, input int stall_at);
        logic [21:0] p;
        logic [17:0] sb;
        int          lat;
        @(negedge clk);
        en = 1'b1; out_ready = 1'b1;
        offer(a, b, p, sb);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready got %b want 1", name, in_ready);
        end
        @(posedge clk);
        wait_done(stall_at, lat);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (mant_out !== p || sb_out() !== sb) begin
            errors++;
            $display("FAIL %s_result got %h/%h want %h/%h", name, mant_out, sb_out(), p, sb);
        end
        @(posedge clk);
    endtask

    task automatic test_basic();
        run_op("one_one", 11'h400, 11'h400, 6, 100);
        checks++;
        if (mant_out !== 22'h100000) begin
            errors++;
            $display("FAIL one_one_const got %h want 100000", mant_out);
        end
        run_op("max_max", 11'h7FF, 11'h7FF, 6, 100);
        checks++;
        if (mant_out !== 22'h3FF001) begin
            errors++;
            $display("FAIL max_max_const got %h want 3FF001", mant_out);
        end
        run_op("mixed", 11'h401, 11'h7FF, 6, 100);
        checks++;
        if (mant_out !== 22'h2003FF) begin
            errors++;
            $display("FAIL mixed_const got %h want 2003FF", mant_out);
        end
        // zero skip finishes on the accepting edge itself
        run_op("zero_a", 11'h000, 11'h5A5, 0, 100);
        run_op("zero_b", 11'h5A5, 11'h000, 0, 100);
    endtask

    task automatic test_stall();
        run_op("stall", 11'h6B5, 11'h59C, 8, 2);
    endtask

    task automatic test_back_to_back();
        logic [21:0] p1, p2;
        logic [17:0] s1, s2;
        int          lat;
        @(negedge clk);
        en = 1'b1; out_ready = 1'b0;
        offer(11'h6D3, 11'h4F1, p1, s1);
        @(posedge clk);
        wait_done(100, lat);
        for (int k = 0; k < 3; k++) begin
            in_valid  = 1'b1;
            mant_a_in = 11'($urandom);
            mant_b_in = 11'($urandom);
            rand_side();
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || mant_out !== p1 || sb_out() !== s1) begin
                errors++;
                $display("FAIL hold_%0d rdy=%b vld=%b mant=%h sb=%h want 0/1/%h/%h",
                         k, in_ready, out_valid, mant_out, sb_out(), p1, s1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        offer(11'h555, 11'h2AB, p2, s2);
        #1;
        checks++;
        if (in_ready !== 1'b1 || mant_out !== p1) begin
            errors++;
            $display("FAIL b2b_accept rdy=%b mant=%h want 1/%h", in_ready, mant_out, p1);
        end
        @(posedge clk);
        wait_done(100, lat);
        checks++;
        if (lat !== 6 || mant_out !== p2 || sb_out() !== s2) begin
            errors++;
            $display("FAIL b2b_second lat=%0d mant=%h sb=%h want 6/%h/%h",
                     lat, mant_out, sb_out(), p2, s2);
        end
        @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [21:0] p;
        logic [17:0] s;
        int          lat;
        @(negedge clk);
        en = 1'b1; out_ready = 1'b1;
        offer(11'h7AB, 11'h3CD, p, s);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mant_out !== '0 || sb_out() !== '0) begin
            errors++;
            $display("FAIL rst_mid vld=%b mant=%h sb=%h want 0/0/0", out_valid, mant_out, sb_out());
        end
        rst = 1'b0;
        offer(11'h513, 11'h6EE, p, s);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready got %b want 1", in_ready);
        end
        @(posedge clk);
        wait_done(100, lat);
        checks++;
        if (lat !== 6 || mant_out !== p || sb_out() !== s) begin
            errors++;
            $display("FAIL rst_mid_fresh lat=%0d mant=%h sb=%h want 6/%h/%h",
                     lat, mant_out, sb_out(), p, s);
        end
        @(posedge clk);
    endtask

    task automatic test_random(input int n);
        logic [39:0] q[$];
        logic [39:0] e;
        for (int i = 0; i < n + 200; i++) begin
            @(negedge clk);
            if (i < n) begin
                en        = ($urandom_range(0, 4) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                in_valid  = 1'($urandom);
                mant_a_in = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
                mant_b_in = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
                rand_side();
            end else begin
                en = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
                if (q.size() == 0) break;
            end
            #1;
            if (out_valid === 1'b1 && out_ready && en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_dup got %h with nothing outstanding", mant_out);
                end else begin
                    e = q.pop_front();
                    if ({mant_out, sb_out()} !== e) begin
                        errors++;
                        $display("FAIL rand_result got %h want %h", {mant_out, sb_out()}, e);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1)
                q.push_back({{11'd0, mant_a_in} * {11'd0, mant_b_in}, sb_in()});
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rand_lost outstanding %0d want 0", q.size());
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_idle out_valid %b want 0", out_valid);
        end
    endtask

    task automatic w_run_op(input string name, input logic [23:0] a,
                            input logic [23:0] b, input int exp_lat);
        logic [47:0] p;
        logic [23:0] sb;
        int          lat;
        @(negedge clk);
        w_en = 1'b1; w_out_ready = 1'b1; w_in_valid = 1'b1;
        w_mant_a_in = a; w_mant_b_in = b; w_rand_side();
        p  = {24'd0, a} * {24'd0, b};
        sb = w_sb_in();
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        w_in_valid = 1'b0;
        while (w_out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== exp_lat || w_mant_out !== p || w_sb_out() !== sb) begin
            errors++;
            $display("FAIL %s lat=%0d mant=%h sb=%h want %0d/%h/%h",
                     name, lat, w_mant_out, w_sb_out(), exp_lat, p, sb);
        end
        @(posedge clk);
    endtask

    task automatic test_wide_random(input int n);
        logic [71:0] q[$];
        logic [71:0] e;
        for (int i = 0; i < n + 400; i++) begin
            @(negedge clk);
            if (i < n) begin
                w_en        = ($urandom_range(0, 4) != 0);
                w_out_ready = ($urandom_range(0, 2) != 0);
                w_in_valid  = 1'($urandom);
                w_mant_a_in = ($urandom_range(0, 15) == 0) ? 24'd0 : 24'($urandom);
                w_mant_b_in = 24'($urandom);
                w_rand_side();
            end else begin
                w_en = 1'b1; w_out_ready = 1'b1; w_in_valid = 1'b0;
                if (q.size() == 0) break;
            end
            #1;
            if (w_out_valid === 1'b1 && w_out_ready && w_en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL wrand_dup got %h with nothing outstanding", w_mant_out);
                end else begin
                    e = q.pop_front();
                    if ({w_mant_out, w_sb_out()} !== e) begin
                        errors++;
                        $display("FAIL wrand_result got %h want %h", {w_mant_out, w_sb_out()}, e);
                    end
                end
            end
            if (w_in_valid && w_in_ready === 1'b1)
                q.push_back({{24'd0, w_mant_a_in} * {24'd0, w_mant_b_in}, w_sb_in()});
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL wrand_lost outstanding %0d want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random(10000);
        w_run_op("w_zero", 24'h000000, 24'h5A5A5A, 13);
        w_run_op("w_max", 24'hFFFFFF, 24'hFFFFFF, 13);
        w_run_op("w_one", 24'h800000, 24'hC00001, 13);
        test_wide_random(10000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
